// File: rtl/ap_mult_err_pkg.sv
// Shared state type and width helpers for the approximate-multiplier error sweep.
package ap_mult_err_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Product of two w-bit operands.
    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

    // Error count: up to 2^(2w) mismatching pairs, so one bit beyond the product.
    function automatic int cnt_w(input int w);
        return 2 * w + 1;
    endfunction

    // Error sum: 2^(2w) pairs, each with an error below 2^(2w).
    function automatic int sum_w(input int w);
        return 4 * w + 1;
    endfunction

endpackage

// File: rtl/ap_mult_err_sweep_if.sv
// Operand/product link between the sweep engine (master) and the multiplier
// under test (slave).
//
// Handshake: op_valid qualifies op_a/op_b in the cycle it is high. There is
// no ready; the multiplier always accepts and returns prod_in a fixed number
// of cycles (DUT_LAT) after the matching op_valid cycle. Operands read 0
// whenever op_valid is low.
interface ap_mult_err_sweep_if #(
    parameter int WIDTH = 12
);
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               op_valid;
    logic [2*WIDTH-1:0] prod_in;

    modport master (output op_a, output op_b, output op_valid, input prod_in);
    modport slave  (input op_a, input op_b, input op_valid, output prod_in);
endinterface

// File: rtl/ap_mult_err_delay.sv
// Fixed-depth register pipeline with a valid bit, used to line the exact
// product up with the multiplier's latency. LAT=0 is a pure bypass.
module ap_mult_err_delay #(
    parameter int LAT = 0,
    parameter int DW  = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    generate
        if (LAT == 0) begin : g_bypass
            // Clock and reset are not needed when the pipe is bypassed.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign valid_o        = valid_i;
            assign data_o         = data_i;
        end else begin : g_pipe
            logic          valid_q [LAT];
            logic [DW-1:0] data_q  [LAT];

            // Valid shift chain; reset clears only the valids.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) valid_q[i] <= 1'b0;
                end else begin
                    valid_q[0] <= valid_i;
                    for (int i = 1; i < LAT; i++) valid_q[i] <= valid_q[i-1];
                end
            end

            // Payload shift chain; qualified by the valids so it needs no reset.
            always_ff @(posedge clk) begin
                data_q[0] <= data_i;
                for (int i = 1; i < LAT; i++) data_q[i] <= data_q[i-1];
            end

            assign valid_o = valid_q[LAT-1];
            assign data_o  = data_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/ap_mult_err_sweep.sv
// Exhaustive error sweep for an approximate multiplier: issues every operand
// pair, compares the returned product with the exact one and accumulates
// error count, sum of absolute error and maximum absolute error.
// Optional feature macro: AP_MULT_ERR_WORST_CAPTURE_EN adds worst_a/worst_b,
// the operands of the first pair that reached the final err_max.
module ap_mult_err_sweep
    import ap_mult_err_pkg::*;
#(
    parameter int WIDTH   = 12,
    parameter int DUT_LAT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output state_e                   dbg_state,
    ap_mult_err_sweep_if.master      bus,
    output logic [cnt_w(WIDTH)-1:0]  err_cnt,
    output logic [sum_w(WIDTH)-1:0]  err_sum,
    output logic [prod_w(WIDTH)-1:0] err_max
`ifdef AP_MULT_ERR_WORST_CAPTURE_EN
    ,
    output logic [WIDTH-1:0]         worst_a,
    output logic [WIDTH-1:0]         worst_b
`endif
);

    localparam int PW  = prod_w(WIDTH);
    localparam int CW  = cnt_w(WIDTH);
    localparam int SW  = sum_w(WIDTH);
    localparam int NW  = 2 * WIDTH;
    localparam int DRW = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;
`ifdef AP_MULT_ERR_WORST_CAPTURE_EN
    localparam int DW  = PW + 2 * WIDTH;
`else
    localparam int DW  = PW;
`endif

    state_e         state_q, state_d;
    logic [NW-1:0]  pair_q, pair_d;
    logic [DRW-1:0] drain_q, drain_d;
    logic           done_q, done_d;
    logic           clear;

    logic           op_valid;
    logic [WIDTH-1:0] op_a, op_b;
    logic [PW-1:0]  exact;
    logic [DW-1:0]  dly_in, dly_out;
    logic           cmp_valid;
    logic [PW-1:0]  cmp_exact;
    logic [PW-1:0]  abs_err;

    logic [CW-1:0]  err_cnt_q, err_cnt_d;
    logic [SW-1:0]  err_sum_q, err_sum_d;
    logic [PW-1:0]  err_max_q, err_max_d;
`ifdef AP_MULT_ERR_WORST_CAPTURE_EN
    logic [WIDTH-1:0] worst_a_q, worst_a_d;
    logic [WIDTH-1:0] worst_b_q, worst_b_d;
`endif

    // Sequencer next state: pair counter walks {a,b} with b fastest.
    always_comb begin
        state_d = state_q;
        pair_d  = pair_q;
        drain_d = drain_q;
        clear   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    clear   = 1'b1;
                    pair_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                pair_d = pair_q + NW'(1);
                if (&pair_q) begin
                    drain_d = '0;
                    state_d = (DUT_LAT == 0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q + DRW'(1);
                if (drain_q == DRW'(DUT_LAT - 1)) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pair_q  <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pair_q  <= pair_d;
            drain_q <= drain_d;
            done_q  <= done_d;
        end
    end

    assign op_valid     = (state_q == ST_RUN);
    assign op_a         = op_valid ? pair_q[NW-1:WIDTH] : '0;
    assign op_b         = op_valid ? pair_q[WIDTH-1:0]  : '0;
    assign bus.op_valid = op_valid;
    assign bus.op_a     = op_a;
    assign bus.op_b     = op_b;
    assign exact        = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};

`ifdef AP_MULT_ERR_WORST_CAPTURE_EN
    assign dly_in = {op_a, op_b, exact};
`else
    assign dly_in = exact;
`endif

    ap_mult_err_delay #(
        .LAT (DUT_LAT),
        .DW  (DW)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .valid_i (op_valid),
        .data_i  (dly_in),
        .valid_o (cmp_valid),
        .data_o  (dly_out)
    );

    assign cmp_exact = dly_out[PW-1:0];

    // Absolute difference between exact and returned product.
    always_comb begin
        abs_err = (cmp_exact >= bus.prod_in) ? cmp_exact - bus.prod_in
                                             : bus.prod_in - cmp_exact;
    end

    // Accumulator next state: cleared on an accepted start, updated on compare.
    always_comb begin
        err_cnt_d = err_cnt_q;
        err_sum_d = err_sum_q;
        err_max_d = err_max_q;
`ifdef AP_MULT_ERR_WORST_CAPTURE_EN
        worst_a_d = worst_a_q;
        worst_b_d = worst_b_q;
`endif
        if (clear) begin
            err_cnt_d = '0;
            err_sum_d = '0;
            err_max_d = '0;
`ifdef AP_MULT_ERR_WORST_CAPTURE_EN
            worst_a_d = '0;
            worst_b_d = '0;
`endif
        end else if (cmp_valid) begin
            err_cnt_d = err_cnt_q + CW'(abs_err != '0);
            err_sum_d = err_sum_q + SW'(abs_err);
            // Strictly greater keeps the first pair that reached the maximum.
            if (abs_err > err_max_q) begin
                err_max_d = abs_err;
`ifdef AP_MULT_ERR_WORST_CAPTURE_EN
                worst_a_d = dly_out[DW-1:DW-WIDTH];
                worst_b_d = dly_out[PW+WIDTH-1:PW];
`endif
            end
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
            err_sum_q <= '0;
            err_max_q <= '0;
`ifdef AP_MULT_ERR_WORST_CAPTURE_EN
            worst_a_q <= '0;
            worst_b_q <= '0;
`endif
        end else begin
            err_cnt_q <= err_cnt_d;
            err_sum_q <= err_sum_d;
            err_max_q <= err_max_d;
`ifdef AP_MULT_ERR_WORST_CAPTURE_EN
            worst_a_q <= worst_a_d;
            worst_b_q <= worst_b_d;
`endif
        end
    end

    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = done_q;
    assign dbg_state = state_q;
    assign err_cnt   = err_cnt_q;
    assign err_sum   = err_sum_q;
    assign err_max   = err_max_q;
`ifdef AP_MULT_ERR_WORST_CAPTURE_EN
    assign worst_a   = worst_a_q;
    assign worst_b   = worst_b_q;
`endif

endmodule

// File: tb/tb_ap_mult_err_sweep.sv
// Bench for ap_mult_err_sweep at WIDTH=4 with stub multipliers.
module tb_ap_mult_err_sweep;
    import ap_mult_err_pkg::*;

    localparam int W  = 4;
    localparam int NP = 256;

    logic clk, rst, start0, start_l;
    int   total, bad;
    int   mode0;
    logic [7:0] tbl [NP];

    // Expected statistics after the first j pairs of a sweep.
    int run_cnt [NP+1];
    int run_sum [NP+1];
    int run_max [NP+1];
    int run_wa  [NP+1];
    int run_wb  [NP+1];

    logic busy0, done0, busy1, done1, busy2, done2;
    state_e st0, st1, st2;
    logic [8:0]  cnt0, cnt1, cnt2;
    logic [16:0] sum0, sum1, sum2;
    logic [7:0]  max0, max1, max2;
`ifdef AP_MULT_ERR_WORST_CAPTURE_EN
    logic [3:0] wa0, wb0, wa1, wb1, wa2, wb2;
`endif

    ap_mult_err_sweep_if #(.WIDTH(W)) bus0 ();
    ap_mult_err_sweep_if #(.WIDTH(W)) bus1 ();
    ap_mult_err_sweep_if #(.WIDTH(W)) bus2 ();

    ap_mult_err_sweep #(.WIDTH(W), .DUT_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .dbg_state(st0), .bus(bus0), .err_cnt(cnt0), .err_sum(sum0), .err_max(max0)
`ifdef AP_MULT_ERR_WORST_CAPTURE_EN
        , .worst_a(wa0), .worst_b(wb0)
`endif
    );

    ap_mult_err_sweep #(.WIDTH(W), .DUT_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_l), .busy(busy1), .done(done1),
        .dbg_state(st1), .bus(bus1), .err_cnt(cnt1), .err_sum(sum1), .err_max(max1)
`ifdef AP_MULT_ERR_WORST_CAPTURE_EN
        , .worst_a(wa1), .worst_b(wb1)
`endif
    );

    ap_mult_err_sweep #(.WIDTH(W), .DUT_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start_l), .busy(busy2), .done(done2),
        .dbg_state(st2), .bus(bus2), .err_cnt(cnt2), .err_sum(sum2), .err_max(max2)
`ifdef AP_MULT_ERR_WORST_CAPTURE_EN
        , .worst_a(wa2), .worst_b(wb2)
`endif
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational stub multiplier for dut0, behaviour chosen by mode0.
    logic [7:0] ex0;
    always_comb begin
        ex0 = {4'b0, bus0.op_a} * {4'b0, bus0.op_b};
        case (mode0)
            0:       bus0.prod_in = ex0;
            1:       bus0.prod_in = ex0 & 8'hFE;
            2:       bus0.prod_in = 8'h00;
            default: bus0.prod_in = tbl[{bus0.op_a, bus0.op_b}];
        endcase
    end

    // Two-stage pipelined exact stubs for dut1 and dut2.
    logic [7:0] p1_s1, p1_s2, p2_s1, p2_s2;
    always @(posedge clk) begin
        p1_s1 <= {4'b0, bus1.op_a} * {4'b0, bus1.op_b};
        p1_s2 <= p1_s1;
        p2_s1 <= {4'b0, bus2.op_a} * {4'b0, bus2.op_b};
        p2_s2 <= p2_s1;
    end
    assign bus1.prod_in = p1_s2;
    assign bus2.prod_in = p2_s2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Product the stub returns for pair k (k = a*16 + b).
    function automatic int stub_val(input int mode, input int k);
        int e;
        e = (k >> 4) * (k & 15);
        case (mode)
            0:       return e;
            1:       return e & 254;
            2:       return 0;
            default: return int'(tbl[k]);
        endcase
    endfunction

    // Reference statistics; shift = how many pairs earlier the seen product belongs to.
    task automatic build_model(input int mode, input int shift);
        int e, p, d;
        run_cnt[0] = 0; run_sum[0] = 0; run_max[0] = 0; run_wa[0] = 0; run_wb[0] = 0;
        for (int k = 0; k < NP; k++) begin
            e = (k >> 4) * (k & 15);
            p = (k - shift < 0) ? 0 : stub_val(mode, k - shift);
            d = (e >= p) ? e - p : p - e;
            run_cnt[k+1] = run_cnt[k] + ((d != 0) ? 1 : 0);
            run_sum[k+1] = run_sum[k] + d;
            if (d > run_max[k]) begin
                run_max[k+1] = d; run_wa[k+1] = k >> 4; run_wb[k+1] = k & 15;
            end else begin
                run_max[k+1] = run_max[k]; run_wa[k+1] = run_wa[k]; run_wb[k+1] = run_wb[k];
            end
        end
    endtask

    task automatic fill_tbl();
        for (int k = 0; k < NP; k++) begin
            if ($urandom_range(0, 3) == 0) tbl[k] = 8'($urandom_range(0, 255));
            else tbl[k] = 8'((k >> 4) * (k & 15));
        end
    endtask

    task automatic check_idle0(input string tag);
        check({tag, " ctl"}, 64'({bus0.op_valid, bus0.op_a, bus0.op_b, busy0, done0}), 64'(0));
        check({tag, " state"}, 64'(st0 == ST_IDLE), 64'(1));
        check({tag, " stats"}, 64'({cnt0, sum0, max0}), 64'(0));
    endtask

    task automatic pin_stats(input string tag, input int c, input int s, input int m);
        check({tag, " err_cnt"}, 64'(cnt0), 64'(c));
        check({tag, " err_sum"}, 64'(sum0), 64'(s));
        check({tag, " err_max"}, 64'(max0), 64'(m));
    endtask

    // Drive one sweep on dut0 and compare every cycle against the model.
    // Called and returns at a negedge. chain_out leaves start high in the DONE cycle.
    task automatic run_sweep(input int mode, input int ign_at, input int abort_at,
                             input bit chain_in, input bit chain_out);
        int j, last;
        logic [10:0] exp_ctl;
        mode0 = mode;
        build_model(mode, 0);
        if (!chain_in) start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        last = chain_out ? NP + 1 : NP + 2;
        for (int c = 1; c <= last; c++) begin
            if (c <= NP) exp_ctl = {1'b1, 8'(c - 1), 1'b1, 1'b0};
            else         exp_ctl = {1'b0, 8'd0, 1'b0, (c == NP + 1)};
            check($sformatf("m%0d c%0d ctl", mode, c),
                  64'({bus0.op_valid, bus0.op_a, bus0.op_b, busy0, done0}), 64'(exp_ctl));
            j = (c - 1 > NP) ? NP : c - 1;
            check($sformatf("m%0d c%0d err_cnt", mode, c), 64'(cnt0), 64'(run_cnt[j]));
            check($sformatf("m%0d c%0d err_sum", mode, c), 64'(sum0), 64'(run_sum[j]));
            check($sformatf("m%0d c%0d err_max", mode, c), 64'(max0), 64'(run_max[j]));
`ifdef AP_MULT_ERR_WORST_CAPTURE_EN
            check($sformatf("m%0d c%0d worst", mode, c), 64'({wa0, wb0}),
                  64'({4'(run_wa[j]), 4'(run_wb[j])}));
`endif
            if (c == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_idle0("abort");
                @(negedge clk);
                check_idle0("abort+1");
                return;
            end
            if (c == last) begin
                if (chain_out) start0 = 1'b1;
            end else begin
                start0 = (c == ign_at);
                @(negedge clk);
            end
        end
    endtask

    // Latency alignment: exact 2-stage stub against DUT_LAT=2 and DUT_LAT=1.
    task automatic run_lat();
        int d1_at, d2_at, n1, n2;
        d1_at = -1; d2_at = -1; n1 = 0; n2 = 0;
        start_l = 1'b1;
        @(negedge clk);
        start_l = 1'b0;
        for (int c = 1; c <= 270; c++) begin
            if (done1) begin n1++; if (d1_at < 0) d1_at = c; end
            if (done2) begin n2++; if (d2_at < 0) d2_at = c; end
            @(negedge clk);
        end
        check("lat2 done cycle", 64'(d2_at), 64'(259));
        check("lat1 done cycle", 64'(d1_at), 64'(258));
        check("lat2 done pulses", 64'(n2), 64'(1));
        check("lat1 done pulses", 64'(n1), 64'(1));
        build_model(0, 0);
        check("lat2 err_cnt", 64'(cnt2), 64'(run_cnt[NP]));
        check("lat2 err_sum", 64'(sum2), 64'(run_sum[NP]));
        check("lat2 err_max", 64'(max2), 64'(run_max[NP]));
        build_model(0, 1);
        check("lat1 err_cnt", 64'(cnt1), 64'(run_cnt[NP]));
        check("lat1 err_sum", 64'(sum1), 64'(run_sum[NP]));
        check("lat1 err_max", 64'(max1), 64'(run_max[NP]));
        check("lat1 misalignment seen", 64'(cnt1 != 0), 64'(1));
        check("lat idle", 64'({busy1, busy2}), 64'(0));
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; start0 = 1'b0; start_l = 1'b0; mode0 = 0;
        for (int k = 0; k < NP; k++) tbl[k] = 8'h00;
        repeat (3) @(negedge clk);
        check_idle0("reset");
        check("reset lat", 64'({busy1, done1, busy2, done2, cnt1, cnt2, max1, max2}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        run_sweep(0, 0, 0, 1'b0, 1'b0);
        pin_stats("exact", 0, 0, 0);
        run_sweep(1, 0, 0, 1'b0, 1'b0);
        pin_stats("lsb0", 64, 64, 1);
        run_sweep(2, 0, 0, 1'b0, 1'b0);
        pin_stats("zero", 225, 14400, 225);
`ifdef AP_MULT_ERR_WORST_CAPTURE_EN
        check("zero worst", 64'({wa0, wb0}), 64'(8'hFF));
`endif

        run_lat();

        run_sweep(1, 0, 101, 1'b0, 1'b0);
        run_sweep(1, int'($urandom_range(2, 250)), 0, 1'b0, 1'b0);
        pin_stats("after abort", 64, 64, 1);

        fill_tbl();
        run_sweep(3, 0, 0, 1'b0, 1'b1);
        run_sweep(3, int'($urandom_range(2, 250)), 0, 1'b1, 1'b0);
        fill_tbl();
        run_sweep(3, int'($urandom_range(2, 250)), 0, 1'b0, 1'b1);
        run_sweep(2, 0, 0, 1'b1, 1'b0);
        pin_stats("chained zero", 225, 14400, 225);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
